// File: rtl/axil_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// axil_sdram_arbiter
//
// Shares one AXI-Lite SDRAM slave port between NUM_MASTERS requesters, such as
// the CPU and the video fetch. Arbitration is round-robin. Only one transaction
// is outstanding at a time. The downstream address, data and strobe are muxed
// by a registered grant. Everything runs in the aclk domain.
//
// Ports (N = NUM_MASTERS; master i occupies bits [i*W +: W] of a packed bus)
//   aclk, aresetn                      clock, synchronous active-low reset
//   s_axil_aw{valid,ready,addr}        per-master write address channel
//   s_axil_w{valid,ready,data,strb}    per-master write data channel
//   s_axil_b{valid,ready,resp}         per-master write response channel
//   s_axil_ar{valid,ready,addr}        per-master read address channel
//   s_axil_r{valid,ready,data,resp}    per-master read data channel
//   m_axil_*                           single AXI-Lite port to the SDRAM slave
//                                      (awprot/arprot are tied to 3'b000)
//
// Response data and handshake outputs are driven only on the granted slot.
// Every other slot reads as 0.
// -----------------------------------------------------------------------------
module axil_sdram_arbiter #(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,

  input  logic [NUM_MASTERS-1:0]            s_axil_awvalid,
  output logic [NUM_MASTERS-1:0]            s_axil_awready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [NUM_MASTERS-1:0]            s_axil_wvalid,
  output logic [NUM_MASTERS-1:0]            s_axil_wready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_axil_wstrb,
  output logic [NUM_MASTERS-1:0]            s_axil_bvalid,
  input  logic [NUM_MASTERS-1:0]            s_axil_bready,
  output logic [NUM_MASTERS*2-1:0]          s_axil_bresp,
  input  logic [NUM_MASTERS-1:0]            s_axil_arvalid,
  output logic [NUM_MASTERS-1:0]            s_axil_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_araddr,
  output logic [NUM_MASTERS-1:0]            s_axil_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_axil_rready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axil_rdata,
  output logic [NUM_MASTERS*2-1:0]          s_axil_rresp,

  output logic                              m_axil_awvalid,
  input  logic                              m_axil_awready,
  output logic [ADDR_WIDTH-1:0]             m_axil_awaddr,
  output logic [2:0]                        m_axil_awprot,
  output logic                              m_axil_wvalid,
  input  logic                              m_axil_wready,
  output logic [DATA_WIDTH-1:0]             m_axil_wdata,
  output logic [STRB_WIDTH-1:0]             m_axil_wstrb,
  input  logic                              m_axil_bvalid,
  output logic                              m_axil_bready,
  input  logic [1:0]                        m_axil_bresp,
  output logic                              m_axil_arvalid,
  input  logic                              m_axil_arready,
  output logic [ADDR_WIDTH-1:0]             m_axil_araddr,
  output logic [2:0]                        m_axil_arprot,
  input  logic                              m_axil_rvalid,
  output logic                              m_axil_rready,
  input  logic [DATA_WIDTH-1:0]             m_axil_rdata,
  input  logic [1:0]                        m_axil_rresp
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } state_t;

  state_t                  state, state_next;
  logic [GW-1:0]           grant, last_grant;
  logic                    aw_done, w_done;
  logic                    aw_done_next, w_done_next;

  logic [NUM_MASTERS-1:0]  wr_req, req;
  logic                    arb_found;
  logic [GW-1:0]           arb_idx, cand;

  // A write needs both AW and W present so the write never stalls
  // half-issued downstream waiting for a lagging channel.
  assign wr_req = s_axil_awvalid & s_axil_wvalid;
  assign req    = wr_req | s_axil_arvalid;

  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;

  // Round-robin search that starts at the slot after the last winner.
  always_comb begin
    // NOTE: every variable gets a default before any branch. Without it,
    // a path that skips an assignment infers a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_MASTERS);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: state is updated with non-blocking assignments. All flops then
    // sample values from before the edge, whatever the statement order.
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);  // master 0 wins the first round
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
      if (state == IDLE && arb_found) begin
        grant      <= arb_idx;
        last_grant <= arb_idx;
      end
    end
  end

  always_comb begin
    state_next     = state;
    aw_done_next   = aw_done;
    w_done_next    = w_done;

    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    s_axil_bresp   = '0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    s_axil_rdata   = '0;
    s_axil_rresp   = '0;

    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;

    // The payload is muxed continuously. Only the valids qualify it.
    m_axil_awaddr  = s_axil_awaddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    m_axil_wdata   = s_axil_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
    m_axil_wstrb   = s_axil_wstrb[grant*STRB_WIDTH +: STRB_WIDTH];
    m_axil_araddr  = s_axil_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];

    unique case (state)
      IDLE: begin
        // If a master has both requests pending, its write goes first.
        if (arb_found) state_next = wr_req[arb_idx] ? WR_ADDR : RD_ADDR;
      end

      RD_ADDR: begin
        m_axil_arvalid        = 1'b1;
        s_axil_arready[grant] = m_axil_arready;
        if (m_axil_arready) state_next = RD_DATA;
      end

      RD_DATA: begin
        s_axil_rvalid[grant]                         = m_axil_rvalid;
        s_axil_rdata[grant*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
        s_axil_rresp[grant*2 +: 2]                   = m_axil_rresp;
        m_axil_rready                                = s_axil_rready[grant];
        if (m_axil_rvalid && s_axil_rready[grant]) state_next = IDLE;
      end

      WR_ADDR: begin
        // AW and W complete independently. A finished channel drops its
        // valid so the slave never sees the same beat twice.
        m_axil_awvalid       = !aw_done;
        m_axil_wvalid        = !w_done;
        s_axil_awready[grant] = m_axil_awready && !aw_done;
        s_axil_wready[grant]  = m_axil_wready && !w_done;
        aw_done_next = aw_done || m_axil_awready;
        w_done_next  = w_done || m_axil_wready;
        if (aw_done_next && w_done_next) begin
          state_next   = WR_RESP;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end

      WR_RESP: begin
        s_axil_bvalid[grant]       = m_axil_bvalid;
        s_axil_bresp[grant*2 +: 2] = m_axil_bresp;
        m_axil_bready              = s_axil_bready[grant];
        if (m_axil_bvalid && s_axil_bready[grant]) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_sdram_arbiter.sv
module tb_axil_sdram_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [7:0]  s_wstrb;
  logic [3:0]  s_bresp, s_rresp;

  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot, m_arprot;
  logic [1:0]  m_bresp, m_rresp;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axil_sdram_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axil_awvalid (s_awvalid),
    .s_axil_awready (s_awready),
    .s_axil_awaddr  (s_awaddr),
    .s_axil_wvalid  (s_wvalid),
    .s_axil_wready  (s_wready),
    .s_axil_wdata   (s_wdata),
    .s_axil_wstrb   (s_wstrb),
    .s_axil_bvalid  (s_bvalid),
    .s_axil_bready  (s_bready),
    .s_axil_bresp   (s_bresp),
    .s_axil_arvalid (s_arvalid),
    .s_axil_arready (s_arready),
    .s_axil_araddr  (s_araddr),
    .s_axil_rvalid  (s_rvalid),
    .s_axil_rready  (s_rready),
    .s_axil_rdata   (s_rdata),
    .s_axil_rresp   (s_rresp),
    .m_axil_awvalid (m_awvalid),
    .m_axil_awready (m_awready),
    .m_axil_awaddr  (m_awaddr),
    .m_axil_awprot  (m_awprot),
    .m_axil_wvalid  (m_wvalid),
    .m_axil_wready  (m_wready),
    .m_axil_wdata   (m_wdata),
    .m_axil_wstrb   (m_wstrb),
    .m_axil_bvalid  (m_bvalid),
    .m_axil_bready  (m_bready),
    .m_axil_bresp   (m_bresp),
    .m_axil_arvalid (m_arvalid),
    .m_axil_arready (m_arready),
    .m_axil_araddr  (m_araddr),
    .m_axil_arprot  (m_arprot),
    .m_axil_rvalid  (m_rvalid),
    .m_axil_rready  (m_rready),
    .m_axil_rdata   (m_rdata),
    .m_axil_rresp   (m_rresp)
  );

  // Every handshake output of the block, expected all-zero when idle or in reset.
  wire [14:0] all_hs = {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock. Inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
    s_awaddr  = '0; s_wdata  = '0; s_wstrb   = '0; s_araddr = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
    m_bresp   = '0; m_rresp = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_inputs();
    step();
    step();
    aresetn = 1'b1;
  endtask

  // One full read while in IDLE with requests pending. The winner must be exp_m.
  task automatic rr_read(input int exp_m, input logic [31:0] exp_addr, input logic [31:0] data);
    check("rr_idle_arvalid", 64'(m_arvalid), 64'd0);
    step();                                  // arbitration edge
    m_arready = 1'b1;
    #1;
    check("rr_araddr", 64'(m_araddr), 64'(exp_addr));
    check("rr_arready", 64'(s_arready), 64'(2'b01 << exp_m));
    step();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = data;
    s_rready  = 2'b11;
    #1;
    check("rr_rvalid", 64'(s_rvalid), 64'(2'b01 << exp_m));
    check("rr_rdata", s_rdata, 64'(data) << (32 * exp_m));
    step();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    #1;
  endtask

  initial begin
    aresetn = 1'b0;
    clear_inputs();
    step();
    step();
    check("reset_hs", 64'(all_hs), 64'd0);
    check("prot_tied", 64'({m_awprot, m_arprot}), 64'd0);
    aresetn = 1'b1;

    // ---- Single M0 read, then a 5-cycle rready stall ------------------------
    s_arvalid = 2'b01;
    s_araddr  = {32'h0000_0000, 32'h0000_0100};
    #1;
    check("t1_idle_no_valid", 64'(m_arvalid), 64'd0);
    step();
    check("t1_arvalid", 64'(m_arvalid), 64'd1);
    check("t1_araddr", 64'(m_araddr), 64'h100);
    m_arready = 1'b1;
    #1;
    check("t1_arready", 64'(s_arready), 64'(2'b01));
    step();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hDEAD_BEEF;
    m_rresp   = 2'b00;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t5_mrready_low", 64'(m_rready), 64'd0);
      check("t1_rvalid_slot0", 64'(s_rvalid), 64'(2'b01));
      check("t1_rdata", s_rdata, 64'h0000_0000_DEAD_BEEF);
      check("t1_rresp", 64'(s_rresp), 64'd0);
      step();
    end
    s_rready = 2'b01;
    #1;
    check("t5_mrready_high", 64'(m_rready), 64'd1);
    step();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    #1;
    check("t1_back_idle", 64'(all_hs), 64'd0);

    // ---- Round-robin with both masters reading continuously -----------------
    do_reset();
    s_arvalid = 2'b11;
    s_araddr  = {32'h0000_2000, 32'h0000_1000};
    rr_read(0, 32'h1000, 32'h1111_0000);
    rr_read(1, 32'h2000, 32'h2222_0001);
    rr_read(0, 32'h1000, 32'h3333_0002);
    rr_read(1, 32'h2000, 32'h4444_0003);
    s_arvalid = 2'b00;
    step();

    // ---- M1 write, slave takes W two cycles before AW -----------------------
    s_awvalid = 2'b10;
    s_wvalid  = 2'b10;
    s_awaddr  = {32'h0000_0200, 32'h0};
    s_wdata   = {32'hA5A5_A5A5, 32'h0};
    s_wstrb   = 8'hF0;
    s_bready  = 2'b10;
    step();
    check("t3_aw_w_valid", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
    check("t3_awaddr", 64'(m_awaddr), 64'h200);
    check("t3_wdata", 64'({m_wdata, m_wstrb}), {28'd0, 32'hA5A5_A5A5, 4'hF});
    m_wready = 1'b1;
    #1;
    check("t3_wready_only", 64'({s_wready, s_awready}), 64'({2'b10, 2'b00}));
    step();
    s_wvalid = 2'b00;
    m_wready = 1'b0;
    #1;
    check("t3_no_dup_w_1", 64'({m_awvalid, m_wvalid}), 64'(2'b10));
    step();
    check("t3_no_dup_w_2", 64'({m_awvalid, m_wvalid}), 64'(2'b10));
    m_awready = 1'b1;
    #1;
    check("t3_awready", 64'(s_awready), 64'(2'b10));
    step();
    s_awvalid = 2'b00;
    m_awready = 1'b0;
    #1;
    check("t3_resp_no_valid", 64'({m_awvalid, m_wvalid, s_bvalid}), 64'd0);
    m_bvalid = 1'b1;
    m_bresp  = 2'b01;
    #1;
    check("t3_bvalid", 64'(s_bvalid), 64'(2'b10));
    check("t3_bresp", 64'(s_bresp), 64'(4'b0100));
    check("t3_bready", 64'(m_bready), 64'd1);
    step();
    m_bvalid = 1'b0;
    s_bready = 2'b00;
    #1;
    check("t3_single_bpulse", 64'(s_bvalid), 64'd0);

    // ---- M0 write and read requested together: write first ----------------
    s_awvalid = 2'b01;
    s_wvalid  = 2'b01;
    s_arvalid = 2'b01;
    s_awaddr  = {32'h0, 32'h0000_0400};
    s_araddr  = {32'h0, 32'h0000_0300};
    s_wdata   = {32'h0, 32'h1234_5678};
    s_wstrb   = 8'h03;
    step();
    check("t4_write_first", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'(3'b110));
    m_awready = 1'b1;
    m_wready  = 1'b1;
    #1;
    check("t4_same_cycle_ready", 64'({s_awready, s_wready}), 64'(4'b0101));
    step();
    s_awvalid = 2'b00;
    s_wvalid  = 2'b00;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b1;
    m_bresp   = 2'b00;
    s_bready  = 2'b01;
    #1;
    check("t4_bvalid_no_ar", 64'({s_bvalid, m_arvalid}), 64'(3'b010));
    step();
    m_bvalid = 1'b0;
    s_bready = 2'b00;
    #1;
    check("t4_idle_gap", 64'(m_arvalid), 64'd0);
    step();
    check("t4_read_after", 64'({m_arvalid, m_araddr}), {31'd0, 1'b1, 32'h300});
    m_arready = 1'b1;
    step();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    s_rready  = 2'b01;
    step();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    #1;

    // ---- Reset during WR_ADDR --------------------------------------------
    // M0 won last, so without a reset M1 would win the next contest.
    s_awvalid = 2'b01;
    s_wvalid  = 2'b01;
    s_awaddr  = {32'h0, 32'h0000_0500};
    step();
    check("t6_in_wr_addr", 64'(m_awvalid), 64'd1);
    aresetn = 1'b0;
    step();
    check("t6_reset_hs", 64'(all_hs), 64'd0);
    aresetn   = 1'b1;
    s_awvalid = 2'b00;
    s_wvalid  = 2'b00;
    s_arvalid = 2'b11;
    s_araddr  = {32'h0000_0B00, 32'h0000_0A00};
    #1;
    check("t6_idle_after_rst", 64'(all_hs), 64'd0);
    step();
    check("t6_m0_granted", 64'({m_arvalid, m_araddr}), {31'd0, 1'b1, 32'hA00});
    m_arready = 1'b1;
    #1;
    check("t6_arready_m0", 64'(s_arready), 64'(2'b01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
